// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame geometry, peripheral register map and
// the controller state encoding. Also used by spi_peripheral.
package spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;

    localparam logic [ADDR_W-1:0] REG_PWM_DUTY   = 7'h00;
    localparam logic [ADDR_W-1:0] REG_PWM_PERIOD = 7'h01;
    localparam logic [ADDR_W-1:0] REG_GPIO_OUT   = 7'h02;
    localparam logic [ADDR_W-1:0] REG_CTRL       = 7'h03;
    localparam logic [ADDR_W-1:0] REG_SCRATCH    = 7'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } ctrl_state_t;

    // Largest of four timing parameters; sizes the shared timing counters.
    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Request/status port of the SPI controller: valid/ready frame request
// plus busy and done status back to the requester.
interface spi_controller_if;
    import spi_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              busy;
    logic              done;

    modport master (
        output req_valid, req_rw, req_addr, req_data,
        input  req_ready, busy, done
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_data,
        output req_ready, busy, done
    );

endinterface

// File: rtl/spi_sclk_phase.sv
// SCLK half-period timer: pulses half_tick on the last clk cycle of each
// half-period while enabled, and sits at zero while disabled.
module spi_sclk_phase #(
    parameter int HALF_DIV = 4,
    parameter int CNT_W    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic half_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_DIV - 1);

    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] phase_d;

    // Count through one half-period, restarting on each tick or when idle.
    always_comb begin
        half_tick = en && (phase_q == LAST);
        phase_d   = phase_q + 1'b1;
        if (!en || half_tick) phase_d = '0;
    end

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) phase_q <= '0;
        else        phase_q <= phase_d;
    end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: accepts one 16-bit {rw, addr, data} frame per
// request and shifts it out MSB first. All pins come straight from flops.
module spi_controller
    import spi_pkg::*;
#(
    parameter int HALF_DIV = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int IDLE_GAP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_controller_if.slave  bus,
    output logic             spi_cs,
    output logic             spi_sclk,
    output logic             spi_copi
);

    localparam int CNT_W = $clog2(max_of4(HALF_DIV, CS_SETUP, CS_HOLD, IDLE_GAP) + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_GAP - 1);

    if (HALF_DIV < 2) begin : g_bad_half_div
        $error("spi_controller: HALF_DIV must be >= 2");
    end
    if (CS_SETUP < 1) begin : g_bad_cs_setup
        $error("spi_controller: CS_SETUP must be >= 1");
    end
    if (CS_HOLD < 1) begin : g_bad_cs_hold
        $error("spi_controller: CS_HOLD must be >= 1");
    end
    if (IDLE_GAP < 1) begin : g_bad_idle_gap
        $error("spi_controller: IDLE_GAP must be >= 1");
    end

    ctrl_state_t        state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [4:0]         bit_q, bit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cs_q, cs_d;
    logic               sclk_q, sclk_d;
    logic               copi_q, copi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               half_tick;

    spi_sclk_phase #(
        .HALF_DIV (HALF_DIV),
        .CNT_W    (CNT_W)
    ) u_phase (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state_q == ST_SHIFT),
        .half_tick (half_tick)
    );

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign spi_cs        = cs_q;
    assign spi_sclk      = sclk_q;
    assign spi_copi      = copi_q;

    // Frame sequencing: next-state and next-pin values for every register.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    shift_d = {bus.req_rw, bus.req_addr, bus.req_data};
                    copi_d  = bus.req_rw;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (half_tick) begin
                    sclk_d = ~sclk_q;
                    // Falling edge: advance to the next bit unless the frame is complete.
                    if (sclk_q) begin
                        if (bit_q == 5'd15) begin
                            cnt_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            bit_d   = bit_q + 5'd1;
                            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                            copi_d  = shift_q[FRAME_W-2];
                        end
                    end
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HOLD_LAST) begin
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP_LAST) begin
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and pin registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule
